disp_mem_arbiter: RTL and testbench
===================================

# disp_mem_arbiter

Shares the single DataMemory port between the CPU and a display fetch engine that feeds the four-digit scan_output driver. While the CPU runs, its bus passes straight through to memory. Once the CPU reports completion, the block takes the port, steps through a window of result words, and latches each word's low 16 bits as the four display nibbles.

## Interface
- BASE_ADDR, 32'h00000004: first word address displayed.
- STEP, 32'h00000004: address increment between displayed words.
- NUM_WORDS, 8: words in the window (1..256); the index wraps after the last word.
- HOLD_TICKS, 100000000: clk cycles each word is held on the display (≥1).
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_done  in  1  CPU execution finished (level; sampled only in RUN).
- cpu_MemRead  in  1  CPU read strobe.
- cpu_MemWrite  in  1  CPU write strobe.
- cpu_Address  in  32  CPU byte address.
- cpu_Write_Data  in  32  CPU write data.
- cpu_Read_Data  out  32  equals mem_Read_Data, combinational, in every state.
- mem_MemRead  out  1  to DataMemory.
- mem_MemWrite  out  1  to DataMemory.
- mem_Address  out  32  to DataMemory.
- mem_Write_Data  out  32  equals cpu_Write_Data, always.
- mem_Read_Data  in  32  from DataMemory; combinational read.
- disp_data  out  16  registered; [15:12]=count_1 … [3:0]=count_4.
- disp_valid  out  1  registered; high once the first word has been latched.
- disp_index  out  8  registered; index of the word currently shown.

## Operation
- States: RUN, DRAIN, FETCH, LATCH, HOLD.
- RUN:
  - mem_MemRead, mem_MemWrite and mem_Address equal the CPU signals, combinationally.
  - If cpu_done=1 at an edge, go to DRAIN.
- DRAIN: one cycle. mem_MemRead=0 and mem_MemWrite=0. Go to FETCH.
- FETCH:
  - mem_Address=addr_reg, mem_MemRead=1, mem_MemWrite=0.
  - Go to LATCH.
- LATCH:
  - Same bus drive as FETCH.
  - At the edge: disp_data←mem_Read_Data[15:0] and disp_valid←1. Go to HOLD with hold counter=0.
- HOLD:
  - Bus is idle: MemRead=0, MemWrite=0, mem_Address=addr_reg.
  - Counter increments each cycle. At count HOLD_TICKS-1, go to FETCH.
  - On that same edge, advance the index: if disp_index=NUM_WORDS-1, then disp_index←0 and addr_reg←BASE_ADDR. Otherwise disp_index+1 and addr_reg+STEP (32-bit, overflow ignored).
- Display mode (all states except RUN) is sticky. Only reset returns the block to RUN; cpu_done dropping has no effect.
- CPU writes in display mode are dropped: mem_MemWrite is forced to 0 whatever cpu_MemWrite does.
- mem_Read_Data[31:16] are ignored.

## Timing
- Reset values: state=RUN, addr_reg=BASE_ADDR, disp_data=16'h0000, disp_valid=0, disp_index=0, hold counter=0.
- Outputs during reset cycles follow RUN (pass-through).
- Reset asserted in any state: at the next edge the block is in RUN with all reset values, regardless of the hold count or any pending fetch.
- Latency, with cpu_done sampled high at edge k:
  - DRAIN after k, FETCH after k+1, LATCH after k+2.
  - disp_data valid and disp_valid=1 after edge k+3.
- Word period is HOLD_TICKS+2 cycles: FETCH, LATCH, then HOLD_TICKS cycles.
- disp_data holds the previous word through FETCH/LATCH and changes only at the LATCH edge. The new disp_index is visible from the end of HOLD.
- NUM_WORDS=1: the same address is refetched every period and disp_index stays 0.

## Configuration
- Macro DISP_BTN_STEP_EN.
- Defined:
  - Adds port step (in, 1), a synchronous debounced button.
  - The block registers step and detects rising edges (step=1 and previous=0).
  - HOLD ignores the counter and goes to FETCH, with the index advance, at the edge a step rising edge is detected.
  - A step held high advances exactly once.
  - The step register resets to 0.
- Not defined: no step port; HOLD_TICKS timer as above.

## Test plan
- Pass-through: after reset, cpu_Address=0x10, cpu_MemWrite=1, cpu_Write_Data=0xABCD → same cycle mem_Address=0x10, mem_MemWrite=1, mem_Write_Data=0xABCD; disp_valid=0, disp_data=0.
- Takeover: params HOLD_TICKS=4, NUM_WORDS=3; mem[0x4]=0x00001234; cpu_done=1 at edge k → mem_Address=0x4 with MemRead=1 in cycles k+2 and k+3; after k+3 disp_data=0x1234, disp_valid=1, disp_index=0.
- Advance/wrap: mem[0x8]=0x5678, mem[0xC]=0x9ABC → disp_data 0x1234→0x5678→0x9ABC→0x1234, changing every 6 cycles; disp_index 0,1,2,0.
- Write block: cpu_MemWrite=1 to 0x4 with data 0xFFFF during HOLD → mem_MemWrite=0, mem[0x4] still 0x1234 on the next wrap.
- Mid-operation reset: assert reset for 1 cycle at hold count 2 → next cycle state=RUN, disp_data=0, disp_valid=0, disp_index=0, CPU pass-through restored; cpu_done=0 afterward keeps the block in RUN.
- DISP_BTN_STEP_EN build: step held high 10 cycles in HOLD → exactly one advance (index 0→1, disp_data=0x5678); no advance without step after 100 cycles.

Source files
------------

// File: rtl/disp_mem_arbiter.sv
// disp_mem_arbiter: shares the DataMemory port between the CPU and a display fetch engine (optional DISP_BTN_STEP_EN adds a step button)
module disp_mem_arbiter #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0004,
    parameter logic [31:0] STEP       = 32'h0000_0004,
    parameter int          NUM_WORDS  = 8,
    parameter int          HOLD_TICKS = 100000000
) (
    input  logic        clk,
    input  logic        reset,
`ifdef DISP_BTN_STEP_EN
    input  logic        step,
`endif
    input  logic        cpu_done,
    input  logic        cpu_MemRead,
    input  logic        cpu_MemWrite,
    input  logic [31:0] cpu_Address,
    input  logic [31:0] cpu_Write_Data,
    output logic [31:0] cpu_Read_Data,
    output logic        mem_MemRead,
    output logic        mem_MemWrite,
    output logic [31:0] mem_Address,
    output logic [31:0] mem_Write_Data,
    input  logic [31:0] mem_Read_Data,
    output logic [15:0] disp_data,
    output logic        disp_valid,
    output logic [7:0]  disp_index
);
    typedef enum logic [2:0] {RUN, DRAIN, FETCH, LATCH, HOLD} state_t;
    state_t      state;
    logic [31:0] addr_reg;
    logic [31:0] hold_cnt;
    logic        adv;
    logic        run_like;
    logic        unused_hi;
    assign unused_hi = &{1'b0, mem_Read_Data[31:16]};
`ifdef DISP_BTN_STEP_EN
    logic step_q;
    // remember the previous button level so a held press advances only once
    always_ff @(posedge clk) step_q <= reset ? 1'b0 : step;
    assign adv = step & ~step_q;
`else
    assign adv = hold_cnt == 32'(HOLD_TICKS - 1);
`endif
    // reset cycles keep the CPU pass-through so the bus never glitches to the display engine
    assign run_like       = reset || state == RUN;
    assign mem_MemRead    = run_like ? cpu_MemRead : (state == FETCH || state == LATCH);
    assign mem_MemWrite   = run_like & cpu_MemWrite;
    assign mem_Address    = run_like ? cpu_Address : addr_reg;
    assign mem_Write_Data = cpu_Write_Data;
    assign cpu_Read_Data  = mem_Read_Data;
    // display sequencer: sticky takeover on cpu_done, then fetch/latch/hold each window word
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= RUN;
            addr_reg   <= BASE_ADDR;
            hold_cnt   <= '0;
            disp_data  <= '0;
            disp_valid <= 1'b0;
            disp_index <= '0;
        end else begin
            case (state)
                RUN:   if (cpu_done) state <= DRAIN;
                DRAIN: state <= FETCH;
                FETCH: state <= LATCH;
                LATCH: begin
                    disp_data  <= mem_Read_Data[15:0];
                    disp_valid <= 1'b1;
                    hold_cnt   <= '0;
                    state      <= HOLD;
                end
                HOLD: begin
                    hold_cnt <= hold_cnt + 32'd1;
                    if (adv) begin
                        state      <= FETCH;
                        disp_index <= disp_index == 8'(NUM_WORDS - 1) ? 8'd0 : disp_index + 8'd1;
                        addr_reg   <= disp_index == 8'(NUM_WORDS - 1) ? BASE_ADDR : addr_reg + STEP;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_disp_mem_arbiter.sv
// tb_disp_mem_arbiter: randomized bus/done/reset stimulus against a word-position reference model
module tb_disp_mem_arbiter;
    localparam logic [31:0] BASE = 32'h4;
    localparam logic [31:0] STP  = 32'h4;
    localparam int          NW   = 3;
    localparam int          HT   = 4;

    logic        clk = 1'b0, reset = 1'b1, cpu_done = 1'b0;
    logic        cpu_MemRead = 1'b0, cpu_MemWrite = 1'b0;
    logic [31:0] cpu_Address = '0, cpu_Write_Data = '0;
    logic [31:0] cpu_Read_Data, mem_Address, mem_Write_Data, mem_Read_Data;
    logic        mem_MemRead, mem_MemWrite, disp_valid;
    logic [15:0] disp_data;
    logic [7:0]  disp_index;
`ifdef DISP_BTN_STEP_EN
    logic        step = 1'b0;
`endif

    logic [31:0] mem [16];
    logic [31:0] mm  [16];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;
    assign mem_Read_Data = mem[mem_Address[5:2]];

    disp_mem_arbiter #(.BASE_ADDR(BASE), .STEP(STP), .NUM_WORDS(NW), .HOLD_TICKS(HT)) dut (
        .clk(clk), .reset(reset),
`ifdef DISP_BTN_STEP_EN
        .step(step),
`endif
        .cpu_done(cpu_done), .cpu_MemRead(cpu_MemRead), .cpu_MemWrite(cpu_MemWrite),
        .cpu_Address(cpu_Address), .cpu_Write_Data(cpu_Write_Data), .cpu_Read_Data(cpu_Read_Data),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_Address(mem_Address),
        .mem_Write_Data(mem_Write_Data), .mem_Read_Data(mem_Read_Data),
        .disp_data(disp_data), .disp_valid(disp_valid), .disp_index(disp_index));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: mode 0=run 1=drain 2=display; n=words started, c=cycle within word (0 fetch, 1 latch, >=2 hold)
    int          mode = 0, n = 0, c = 0;
    logic [15:0] dd = '0;
    logic        dv = 1'b0, sp = 1'b0;

    initial begin
        logic        run_like, wr, adv, stp;
        logic [31:0] ea, wa, wd;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            mm[i]  = mem[i];
        end
        mem[1] = 32'h0000_1234; mem[2] = 32'h0000_5678; mem[3] = 32'h0000_9ABC;
        mm[1]  = mem[1];        mm[2]  = mem[2];        mm[3]  = mem[3];
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            reset          = (cyc < 2) || ($urandom_range(0, 399) == 0);
            cpu_done       = mode == 0 ? ($urandom_range(0, 29) == 0) : $urandom_range(0, 1) == 1;
            cpu_MemRead    = 1'($urandom);
            cpu_MemWrite   = 1'($urandom);
            cpu_Address    = $urandom & 32'h3C;
            cpu_Write_Data = $urandom;
`ifdef DISP_BTN_STEP_EN
            if ($urandom_range(0, 5) == 0) step = ~step;
            stp = step;
`else
            stp = 1'b0;
`endif
            #1;
            run_like = reset || mode == 0;
            ea = run_like ? cpu_Address : BASE + STP * 32'(n % NW);
            check("mem_rd",   32'(mem_MemRead),  32'(run_like ? cpu_MemRead : (mode == 2 && c < 2)));
            check("mem_wr",   32'(mem_MemWrite), 32'(run_like & cpu_MemWrite));
            check("mem_wdata", mem_Write_Data, cpu_Write_Data);
            if (mode != 1 || run_like) begin
                check("mem_addr", mem_Address, ea);
                check("cpu_rdata", cpu_Read_Data, mem[ea[5:2]]);
            end
            check("disp_data",  32'(disp_data),  32'(dd));
            check("disp_valid", 32'(disp_valid), 32'(dv));
            check("disp_index", 32'(disp_index), 32'(mode == 2 ? n % NW : 0));
            wr = mem_MemWrite; wa = mem_Address; wd = mem_Write_Data;
            @(posedge clk);
            if (wr) mem[wa[5:2]] = wd;
            if (run_like && cpu_MemWrite) mm[cpu_Address[5:2]] = cpu_Write_Data;
`ifdef DISP_BTN_STEP_EN
            adv = stp && !sp;
`else
            adv = c == HT + 1;
`endif
            if (reset) begin
                mode = 0; n = 0; c = 0; dd = '0; dv = 1'b0;
            end else if (mode == 0) begin
                if (cpu_done) mode = 1;
            end else if (mode == 1) begin
                mode = 2; n = 0; c = 0;
            end else begin
                if (c == 1) begin
                    ea = BASE + STP * 32'(n % NW);
                    dd = mm[ea[5:2]][15:0];
                    dv = 1'b1;
                end
                if (c >= 2 && adv) begin
                    n++;
                    c = 0;
                end else c++;
            end
            sp = reset ? 1'b0 : stp;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
